sync_fifo_param: RTL and testbench

//  Parametrised single-clock FIFO; inferred-RAM successor to the 7-series FIFO18E1 wrapper.

---
 rtl/sync_fifo_param.sv | 217 +++++++++++++++++++++
 tb/tb_sync_fifo_param.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_param.sv
// -----------------------------------------------------------------------------
// sync_fifo_param
//
// Parametrised single-clock FIFO with first-word-fall-through output, built on
// an inferred RAM plus one output register. The head word sits in the output
// register, so rd_data is valid whenever o_empty is low. A small clear
// sequencer runs after reset and after i_flush. It holds o_active low while
// the FIFO empties itself, then re-opens it to traffic.
//
// Parameters
//   WIDTH        data width in bits
//   DEPTH_LOG2   capacity DEPTH = 2**DEPTH_LOG2 entries (output register included)
//   READY_SLACK  o_ready is high while free entries >= READY_SLACK
//   CLEAR_CYCLES o_active stays low this many edges after a clear starts
//
// Ports
//   clk       in   clock, all logic on posedge
//   reset_n   in   asynchronous active-low reset
//   i_flush   in   synchronous clear request (ignored while o_active=0)
//   wr_data   in   write data
//   wr_en     in   write request
//   rd_en     in   pop request for the word on rd_data
//   rd_data   out  head word, valid when o_empty=0
//   o_empty   out  no word presented on rd_data
//   o_full    out  o_count == DEPTH
//   o_ready   out  (DEPTH - o_count) >= READY_SLACK
//   o_count   out  words held, including the output register and in-flight word
//   o_active  out  FIFO accepting traffic
//
// Optional build macro SYNC_FIFO_ERR_EN adds:
//   o_wr_err  out  sticky: write rejected because the FIFO was full
//   o_rd_err  out  sticky: read ignored because the FIFO was empty
// -----------------------------------------------------------------------------
module sync_fifo_param #(
  parameter int WIDTH        = 16,
  parameter int DEPTH_LOG2   = 9,
  parameter int READY_SLACK  = 16,
  parameter int CLEAR_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_flush,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  wr_en,
  input  logic                  rd_en,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  o_empty,
  output logic                  o_full,
  output logic                  o_ready,
  output logic [DEPTH_LOG2:0]   o_count,
  output logic                  o_active
`ifdef SYNC_FIFO_ERR_EN
  ,
  output logic                  o_wr_err,
  output logic                  o_rd_err
`endif
);

  localparam int                  DEPTH     = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] SLACK_CNT = (DEPTH_LOG2 + 1)'(READY_SLACK);
  // The WAIT counter is loaded on leaving CLEAR. CLEAR itself accounts for
  // one edge, so WAIT must last CLEAR_CYCLES-1 edges.
  localparam logic [5:0]          WAIT_LOAD = 6'(CLEAR_CYCLES >= 2 ? CLEAR_CYCLES - 2 : 0);
  localparam bit                  SKIP_WAIT = (CLEAR_CYCLES == 1);

  typedef enum logic [1:0] {
    ST_CLEAR  = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;

  state_t                  state;
  logic [5:0]              wait_cnt;

  logic [WIDTH-1:0]        mem [DEPTH];
  logic [DEPTH_LOG2-1:0]   wr_ptr;
  logic [DEPTH_LOG2-1:0]   rd_ptr;
  logic                    out_valid;

  logic                    clear_now;
  logic                    wr_acc;
  logic                    rd_acc;
  logic [DEPTH_LOG2:0]     ram_cnt;
  logic                    fetch;

  // ---------------------------------------------------------------------------
  // Clear sequencer: CLEAR (1 edge) -> WAIT (CLEAR_CYCLES-1 edges) -> ACTIVE.
  // o_active is registered alongside the state. It is high exactly in ACTIVE.
  // ---------------------------------------------------------------------------
  // NOTE: every clocked block uses non-blocking (<=) assignments so that all
  // registers sample their inputs from the same edge, regardless of block order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_CLEAR;
      wait_cnt <= '0;
      o_active <= 1'b0;
    end else begin
      case (state)
        ST_ACTIVE: begin
          if (i_flush) begin
            state    <= ST_CLEAR;
            o_active <= 1'b0;
          end
        end
        ST_CLEAR: begin
          if (SKIP_WAIT) begin
            state    <= ST_ACTIVE;
            o_active <= 1'b1;
          end else begin
            state    <= ST_WAIT;
            wait_cnt <= WAIT_LOAD;
          end
        end
        ST_WAIT: begin
          if (wait_cnt == 6'd0) begin
            state    <= ST_ACTIVE;
            o_active <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 6'd1;
          end
        end
        default: begin
          state    <= ST_CLEAR;
          o_active <= 1'b0;
        end
      endcase
    end
  end

  // The FIFO is emptied on the flush edge itself and again while in CLEAR.
  // This means o_count reads zero immediately after the flush edge.
  assign clear_now = (state == ST_CLEAR) || (o_active && i_flush);

  // Transfers only count while ACTIVE. A full write is rejected even when a
  // pop happens on the same edge.
  assign wr_acc = o_active && wr_en && !o_full;
  assign rd_acc = o_active && rd_en && out_valid;

  // Words still in RAM: o_count minus the one in the output register.
  assign ram_cnt = o_count - {{DEPTH_LOG2{1'b0}}, out_valid};

  // The output register refills from RAM when it is empty, or on the same edge
  // it is popped. This gives back-to-back reads at one word per clock.
  assign fetch = (ram_cnt != '0) && (!out_valid || rd_acc);

  // ---------------------------------------------------------------------------
  // Storage. RAM occupancy never exceeds DEPTH-1 while the output register is
  // valid, so wr_ptr never overtakes rd_ptr and a read never aliases a write.
  // ---------------------------------------------------------------------------
  // NOTE: the RAM array has no reset. Stale contents are never visible because
  // the pointers and count are reset, and an unreset array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      o_count   <= '0;
      out_valid <= 1'b0;
      rd_data   <= '0;
    end else if (clear_now) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      o_count   <= '0;
      out_valid <= 1'b0;
      rd_data   <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
      end

      if (fetch) begin
        rd_data   <= mem[rd_ptr];
        rd_ptr    <= rd_ptr + 1'b1;
        out_valid <= 1'b1;
      end else if (rd_acc) begin
        out_valid <= 1'b0;
      end

      case ({wr_acc, rd_acc})
        2'b10:   o_count <= o_count + 1'b1;
        2'b01:   o_count <= o_count - 1'b1;
        default: o_count <= o_count;
      endcase
    end
  end

  assign o_empty = !out_valid;
  assign o_full  = (o_count == DEPTH_CNT);
  assign o_ready = ((DEPTH_CNT - o_count) >= SLACK_CNT);

`ifdef SYNC_FIFO_ERR_EN
  // Sticky error flags. They are cleared by reset and by the clear sequence.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_wr_err <= 1'b0;
      o_rd_err <= 1'b0;
    end else if (clear_now) begin
      o_wr_err <= 1'b0;
      o_rd_err <= 1'b0;
    end else begin
      if (o_active && wr_en && o_full) begin
        o_wr_err <= 1'b1;
      end
      if (o_active && rd_en && !out_valid) begin
        o_rd_err <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// -----------------------------------------------------------------------------
// Directed testbench for sync_fifo_param with default parameters
// (WIDTH=16, DEPTH=512, READY_SLACK=16, CLEAR_CYCLES=4). Inputs are driven
// 1 ns after each rising edge, and outputs are sampled at that same point.
// -----------------------------------------------------------------------------
module tb_sync_fifo_param;

  localparam int WIDTH      = 16;
  localparam int DEPTH_LOG2 = 9;
  localparam int DEPTH      = 512;

  logic                clk = 1'b0;
  logic                reset_n;
  logic                i_flush;
  logic [WIDTH-1:0]    wr_data;
  logic                wr_en;
  logic                rd_en;
  logic [WIDTH-1:0]    rd_data;
  logic                o_empty;
  logic                o_full;
  logic                o_ready;
  logic [DEPTH_LOG2:0] o_count;
  logic                o_active;
`ifdef SYNC_FIFO_ERR_EN
  logic                o_wr_err;
  logic                o_rd_err;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  sync_fifo_param #(
    .WIDTH        (WIDTH),
    .DEPTH_LOG2   (DEPTH_LOG2),
    .READY_SLACK  (16),
    .CLEAR_CYCLES (4)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_flush  (i_flush),
    .wr_data  (wr_data),
    .wr_en    (wr_en),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .o_empty  (o_empty),
    .o_full   (o_full),
    .o_ready  (o_ready),
    .o_count  (o_count),
    .o_active (o_active)
`ifdef SYNC_FIFO_ERR_EN
    ,
    .o_wr_err (o_wr_err),
    .o_rd_err (o_rd_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 ns past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int wr_v;
    int rd_v;

    reset_n = 1'b0;
    i_flush = 1'b0;
    wr_data = '0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    step();
    step();

    // ---- reset state ----
    check("rst_active", o_active, 0);
    check("rst_empty",  o_empty,  1);
    check("rst_full",   o_full,   0);
    check("rst_ready",  o_ready,  1);
    check("rst_count",  o_count,  0);
    check("rst_rdata",  rd_data,  0);
`ifdef SYNC_FIFO_ERR_EN
    check("rst_wr_err", o_wr_err, 0);
    check("rst_rd_err", o_rd_err, 0);
`endif

    // ---- reset release: o_active rises on the 4th edge. Writes before that are ignored ----
    reset_n = 1'b1;
    wr_en   = 1'b1;
    wr_data = 16'hdead;
    for (int i = 1; i <= 3; i++) begin
      step();
      check($sformatf("pre_active_e%0d", i), o_active, 0);
      check($sformatf("pre_count_e%0d", i),  o_count,  0);
    end
    step();
    check("active_e4",    o_active, 1);
    wr_en = 1'b0;
    check("active_count", o_count,  0);
    check("active_empty", o_empty,  1);

    // ---- single word latency ----
    wr_data = 16'h1234;
    wr_en   = 1'b1;
    step();
    wr_en = 1'b0;
    check("lat_empty_k",   o_empty, 1);
    check("lat_count_k",   o_count, 1);
    step();
    check("lat_empty_k1",  o_empty, 0);
    check("lat_rdata_k1",  rd_data, 16'h1234);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    check("pop_empty",     o_empty, 1);
    check("pop_count",     o_count, 0);

    // ---- fill 0..511 ----
    wr_en = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      wr_data = 16'(i);
      step();
      if (i == 495) check("ready_at_496", o_ready, 1);
      if (i == 496) check("ready_at_497", o_ready, 0);
      if (i == 510) check("notfull_511",  o_full,  0);
    end
    check("fill_count", o_count, 512);
    check("fill_full",  o_full,  1);
    check("fill_ready", o_ready, 0);
    wr_data = 16'hffff;
    step();
    wr_en = 1'b0;
    check("overfill_count", o_count, 512);
    check("overfill_full",  o_full,  1);
`ifdef SYNC_FIFO_ERR_EN
    check("wr_err_set",     o_wr_err, 1);
    check("rd_err_clear",   o_rd_err, 0);
`endif

    // ---- drain in order ----
    rd_en = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      check($sformatf("drain_data_%0d", i), rd_data, 64'(i));
      step();
    end
    rd_en = 1'b0;
    check("drain_empty", o_empty, 1);
    check("drain_count", o_count, 0);
    check("drain_ready", o_ready, 1);

    // ---- read while empty is ignored ----
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    check("empty_rd_count", o_count, 0);
    check("empty_rd_empty", o_empty, 1);
`ifdef SYNC_FIFO_ERR_EN
    check("rd_err_set",     o_rd_err, 1);
    check("wr_err_sticky",  o_wr_err, 1);
`endif

    // ---- half full, simultaneous read+write across pointer wrap ----
    wr_v  = 0;
    rd_v  = 0;
    wr_en = 1'b1;
    for (int i = 0; i < DEPTH / 2; i++) begin
      wr_data = 16'(wr_v + 16'h1000);
      wr_v++;
      step();
    end
    wr_en = 1'b0;
    step();
    check("half_count", o_count, 256);
    wr_en = 1'b1;
    rd_en = 1'b1;
    for (int i = 0; i < 3 * DEPTH; i++) begin
      wr_data = 16'(wr_v + 16'h1000);
      wr_v++;
      check($sformatf("wrap_data_%0d", i), rd_data, 64'(16'(rd_v + 16'h1000)));
      rd_v++;
      step();
      check($sformatf("wrap_count_%0d", i), o_count, 256);
    end
    wr_en = 1'b0;

    // ---- drain down to 100 words, still in order ----
    for (int i = 0; i < 156; i++) begin
      check($sformatf("part_data_%0d", i), rd_data, 64'(16'(rd_v + 16'h1000)));
      rd_v++;
      step();
    end
    rd_en = 1'b0;
    check("pre_flush_count", o_count, 100);

    // ---- flush at count 100 ----
    i_flush = 1'b1;
    step();
    i_flush = 1'b0;
    check("flush_active", o_active, 0);
    check("flush_count",  o_count,  0);
    check("flush_empty",  o_empty,  1);
`ifdef SYNC_FIFO_ERR_EN
    check("flush_wr_err", o_wr_err, 0);
    check("flush_rd_err", o_rd_err, 0);
`endif
    for (int i = 1; i <= 3; i++) begin
      step();
      check($sformatf("flush_wait_e%0d", i), o_active, 0);
    end
    step();
    check("flush_reactive", o_active, 1);
    check("flush_re_count", o_count,  0);

    // ---- traffic resumes after flush ----
    wr_data = 16'hbeef;
    wr_en   = 1'b1;
    step();
    wr_en = 1'b0;
    step();
    check("post_flush_data",  rd_data, 16'hbeef);
    check("post_flush_count", o_count, 1);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
